// File: rtl/opb_master_pkg.sv
// Shared types and constants for the OPB command master.
package opb_master_pkg;
  localparam int OPB_AW  = 32;
  localparam int OPB_DW  = 32;
  localparam int OPB_BEW = 4;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_ERR     = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_RETRY   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_XFER    = 3'd2,
    S_BACKOFF = 3'd3,
    S_RESP    = 3'd4
  } state_e;

  typedef struct packed {
    logic               rnw;
    logic [0:OPB_AW-1]  addr;
    logic [0:OPB_BEW-1] be;
    logic [0:OPB_DW-1]  wdata;
  } cmd_t;
endpackage

// File: rtl/opb_cmd_master_if.sv
// Command/response handshake plus OPB master-side bus signals.
interface opb_cmd_master_if;
  import opb_master_pkg::*;

  logic               cmd_valid, cmd_ready, cmd_rnw;
  logic [0:OPB_AW-1]  cmd_addr;
  logic [0:OPB_BEW-1] cmd_be;
  logic [0:OPB_DW-1]  cmd_wdata;
  logic               resp_valid, resp_ready;
  logic [0:OPB_DW-1]  resp_rdata;
  logic [1:0]         resp_status;
  logic               M_request, OPB_MGrant, M_select, M_RNW, M_seqAddr;
  logic [0:OPB_AW-1]  M_ABus;
  logic [0:OPB_BEW-1] M_BE;
  logic [0:OPB_DW-1]  M_DBus, OPB_DBus;
  logic               OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup;

  modport master (
    input  cmd_valid, cmd_rnw, cmd_addr, cmd_be, cmd_wdata, resp_ready,
           OPB_MGrant, OPB_DBus, OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup,
    output cmd_ready, resp_valid, resp_rdata, resp_status,
           M_request, M_select, M_RNW, M_ABus, M_BE, M_DBus, M_seqAddr
  );

  modport slave (
    output cmd_valid, cmd_rnw, cmd_addr, cmd_be, cmd_wdata, resp_ready,
           OPB_MGrant, OPB_DBus, OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup,
    input  cmd_ready, resp_valid, resp_rdata, resp_status,
           M_request, M_select, M_RNW, M_ABus, M_BE, M_DBus, M_seqAddr
  );
endinterface

// File: rtl/opb_cmd_master.sv
// Single-word OPB bus master: one request/grant/select/ack transfer per command,
// with retry backoff and an xferAck timeout.
module opb_cmd_master
  import opb_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_RETRY      = 3
) (
  input  logic              OPB_Clk,
  input  logic              OPB_Rst,
  opb_cmd_master_if.master  bus
);
  localparam logic [7:0] TOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

  state_e             state_q, state_d;
  cmd_t               hold_q, hold_d;
  logic [7:0]         tout_q, tout_d;
  logic [3:0]         retry_q, retry_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               resp_valid_q, resp_valid_d;
  logic [0:OPB_DW-1]  resp_rdata_q, resp_rdata_d;
  logic [1:0]         resp_status_q, resp_status_d;
  logic               m_request_q, m_request_d;
  logic               m_select_q, m_select_d;
  logic               m_rnw_q, m_rnw_d;
  logic [0:OPB_AW-1]  m_abus_q, m_abus_d;
  logic [0:OPB_BEW-1] m_be_q, m_be_d;
  logic [0:OPB_DW-1]  m_dbus_q, m_dbus_d;
  logic               drop_bus;

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    tout_d        = tout_q;
    retry_d       = retry_q;
    cmd_ready_d   = cmd_ready_q;
    resp_valid_d  = resp_valid_q;
    resp_rdata_d  = resp_rdata_q;
    resp_status_d = resp_status_q;
    m_request_d   = m_request_q;
    m_select_d    = m_select_q;
    m_rnw_d       = m_rnw_q;
    m_abus_d      = m_abus_q;
    m_be_d        = m_be_q;
    m_dbus_d      = m_dbus_q;
    drop_bus      = 1'b0;

    case (state_q)
      S_IDLE: if (bus.cmd_valid && cmd_ready_q) begin
        hold_d      = '{rnw: bus.cmd_rnw, addr: bus.cmd_addr, be: bus.cmd_be, wdata: bus.cmd_wdata};
        retry_d     = '0;
        cmd_ready_d = 1'b0;
        m_request_d = 1'b1;
        state_d     = S_REQ;
      end
      S_REQ: if (bus.OPB_MGrant) begin
        m_request_d = 1'b0;
        m_select_d  = 1'b1;
        m_rnw_d     = hold_q.rnw;
        m_abus_d    = hold_q.addr;
        m_be_d      = hold_q.be;
        m_dbus_d    = hold_q.rnw ? '0 : hold_q.wdata;
        tout_d      = '0;
        state_d     = S_XFER;
      end
      S_XFER: begin
        // Terminations are prioritised errAck > xferAck > retry > timeout.
        if (bus.OPB_errAck) begin
          drop_bus = 1'b1; resp_valid_d = 1'b1; resp_status_d = ST_ERR;
          resp_rdata_d = '0; state_d = S_RESP;
        end else if (bus.OPB_xferAck) begin
          drop_bus = 1'b1; resp_valid_d = 1'b1; resp_status_d = ST_OK;
          resp_rdata_d = hold_q.rnw ? bus.OPB_DBus : '0; state_d = S_RESP;
        end else if (bus.OPB_retry) begin
          drop_bus = 1'b1;
          if (retry_q == RETRY_MAX) begin
            resp_valid_d = 1'b1; resp_status_d = ST_RETRY;
            resp_rdata_d = '0; state_d = S_RESP;
          end else begin
            retry_d = retry_q + 4'd1;
            state_d = S_BACKOFF;
          end
        end else if (!bus.OPB_toutSup) begin
          if (tout_q == TOUT_LAST) begin
            drop_bus = 1'b1; resp_valid_d = 1'b1; resp_status_d = ST_TIMEOUT;
            resp_rdata_d = '0; state_d = S_RESP;
          end else begin
            tout_d = tout_q + 8'd1;
          end
        end
      end
      S_BACKOFF: begin
        m_request_d = 1'b1;
        state_d     = S_REQ;
      end
      S_RESP: if (bus.resp_ready) begin
        resp_valid_d  = 1'b0;
        resp_rdata_d  = '0;
        resp_status_d = ST_OK;
        cmd_ready_d   = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Bus outputs are OR-ed onto the shared OPB, so they must be zero when not selected.
    if (drop_bus) begin
      m_select_d = 1'b0;
      m_rnw_d    = 1'b0;
      m_abus_d   = '0;
      m_be_d     = '0;
      m_dbus_d   = '0;
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q       <= S_IDLE;
      hold_q        <= '0;
      tout_q        <= '0;
      retry_q       <= '0;
      cmd_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_status_q <= ST_OK;
      m_request_q   <= 1'b0;
      m_select_q    <= 1'b0;
      m_rnw_q       <= 1'b0;
      m_abus_q      <= '0;
      m_be_q        <= '0;
      m_dbus_q      <= '0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      tout_q        <= tout_d;
      retry_q       <= retry_d;
      cmd_ready_q   <= cmd_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_status_q <= resp_status_d;
      m_request_q   <= m_request_d;
      m_select_q    <= m_select_d;
      m_rnw_q       <= m_rnw_d;
      m_abus_q      <= m_abus_d;
      m_be_q        <= m_be_d;
      m_dbus_q      <= m_dbus_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.resp_status = resp_status_q;
  assign bus.M_request   = m_request_q;
  assign bus.M_select    = m_select_q;
  assign bus.M_RNW       = m_rnw_q;
  assign bus.M_ABus      = m_abus_q;
  assign bus.M_BE        = m_be_q;
  assign bus.M_DBus      = m_dbus_q;
  assign bus.M_seqAddr   = 1'b0;
endmodule

// File: tb/tb_opb_cmd_master.sv
// Randomized bench for opb_cmd_master: scripted arbiter/slave per command and a
// transaction-level outcome model.
module tb_opb_cmd_master;
  import opb_master_pkg::*;

  localparam int TOUT   = 16;
  localparam int MRETRY = 3;
  localparam int K_ACK = 0, K_ERR = 1, K_BOTH = 2, K_RETRY = 3, K_NONE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  opb_cmd_master_if bus();
  opb_cmd_master #(.TIMEOUT_CYCLES(TOUT), .MAX_RETRY(MRETRY)) dut (
    .OPB_Clk(clk), .OPB_Rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // Per-command plan: one entry per bus attempt (grant delay, slave event kind, XFER cycle of event)
  int          p_n;
  int          p_gdel [16];
  int          p_kind [16];
  int          p_at   [16];
  logic        p_rnw, p_tsup;
  logic [31:0] p_addr, p_wdata, p_rdata;
  logic [3:0]  p_be;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_plan(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input logic [31:0] rdata, input logic tsup);
    p_rnw = rnw; p_addr = addr; p_be = be; p_wdata = wdata; p_rdata = rdata; p_tsup = tsup;
    p_n = 1;
    for (int i = 0; i < 16; i++) begin p_gdel[i] = 0; p_kind[i] = K_ACK; p_at[i] = 1; end
  endtask

  task automatic rand_plan();
    int r;
    set_plan(1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom, $urandom,
             1'($urandom_range(0, 4) == 0));
    p_n = $urandom_range(1, MRETRY + 1);
    for (int i = 0; i < p_n; i++) begin
      p_gdel[i] = $urandom_range(0, 3);
      p_kind[i] = K_RETRY;
      p_at[i]   = $urandom_range(1, 6);
    end
    if (p_n == MRETRY + 1) r = $urandom_range(0, 4);
    else begin r = $urandom_range(0, 3); if (r == 3) r = K_NONE; end
    if (p_tsup && r == K_NONE) r = K_ACK;
    p_kind[p_n-1] = r;
    p_at[p_n-1]   = $urandom_range(1, 20);
  endtask

  // Outcome from the rules: XFER cycles spent, backoffs, final status and data.
  task automatic model(output logic [1:0] st, output logic [31:0] rd, output int sel, output int boff);
    st = ST_OK; rd = '0; sel = 0; boff = 0;
    for (int a = 0; a < p_n; a++) begin
      if (!p_tsup && (p_kind[a] == K_NONE || p_at[a] > TOUT)) begin
        sel += TOUT; st = ST_TIMEOUT; break;
      end
      sel += p_at[a];
      if (p_kind[a] == K_ACK) begin st = ST_OK; rd = p_rnw ? p_rdata : 32'h0; break; end
      if (p_kind[a] == K_ERR || p_kind[a] == K_BOTH) begin st = ST_ERR; break; end
      if (a == MRETRY) begin st = ST_RETRY; break; end
      boff++;
    end
  endtask

  task automatic idle_inputs();
    bus.OPB_MGrant = 0; bus.OPB_xferAck = 0; bus.OPB_errAck = 0; bus.OPB_retry = 0;
    bus.OPB_toutSup = 0; bus.OPB_DBus = '0; bus.resp_ready = 0;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the response handshake.
  task automatic run_cmd(input int rr_delay);
    logic [1:0]  est;
    logic [31:0] erd;
    int esel, eboff;
    int a = 0, xk = 0, gcnt = 0, sel = 0, boff = 0, bus_bad = 0, resp_bad = 0, rrc = 0, guard = 0;
    bit prev_sel = 0, seen = 0, done = 0;
    model(est, erd, esel, eboff);
    chk("cmd_ready_idle", 32'(bus.cmd_ready), 1);
    bus.cmd_valid = 1; bus.cmd_rnw = p_rnw; bus.cmd_addr = p_addr;
    bus.cmd_be = p_be; bus.cmd_wdata = p_wdata; bus.OPB_toutSup = p_tsup;
    @(negedge clk);
    bus.cmd_valid = 0; bus.cmd_rnw = ~p_rnw; bus.cmd_addr = $urandom;
    bus.cmd_be = 4'($urandom); bus.cmd_wdata = $urandom;
    while (!done && guard < 2000) begin
      guard++;
      if (bus.M_select) begin
        if (!prev_sel) xk = 0;
        xk++; sel++;
        if (bus.M_ABus !== p_addr || bus.M_BE !== p_be || bus.M_RNW !== p_rnw ||
            bus.M_DBus !== (p_rnw ? 32'h0 : p_wdata)) bus_bad++;
      end else if (bus.M_ABus !== '0 || bus.M_BE !== '0 || bus.M_RNW !== 1'b0 || bus.M_DBus !== '0)
        bus_bad++;
      if (bus.M_seqAddr !== 1'b0) bus_bad++;
      if (!bus.cmd_ready && !bus.M_request && !bus.M_select && !bus.resp_valid) boff++;

      bus.OPB_xferAck = 0; bus.OPB_errAck = 0; bus.OPB_retry = 0; bus.OPB_DBus = $urandom;
      if (bus.M_request) begin bus.OPB_MGrant = (gcnt >= p_gdel[a]); gcnt++; end
      else begin bus.OPB_MGrant = 1'($urandom_range(0, 1)); gcnt = 0; end
      if (bus.M_select && p_kind[a] != K_NONE && xk == p_at[a]) begin
        case (p_kind[a])
          K_ACK:   begin bus.OPB_xferAck = 1; bus.OPB_DBus = p_rdata; end
          K_ERR:   bus.OPB_errAck = 1;
          K_BOTH:  begin bus.OPB_xferAck = 1; bus.OPB_errAck = 1; bus.OPB_DBus = p_rdata; end
          default: bus.OPB_retry = 1;
        endcase
        if (p_kind[a] == K_RETRY) a++;
      end

      if (bus.resp_valid) begin
        if (!seen) begin
          seen = 1;
          chk("resp_latency", 32'(prev_sel), 1);
          chk("resp_status", 32'(bus.resp_status), 32'(est));
          chk("resp_rdata", bus.resp_rdata, erd);
        end else if (bus.resp_status !== est || bus.resp_rdata !== erd || bus.cmd_ready !== 1'b0)
          resp_bad++;
        if (rrc >= rr_delay) done = 1; else rrc++;
        bus.resp_ready = done;
      end else bus.resp_ready = 1'($urandom_range(0, 1));
      prev_sel = bus.M_select;
      @(negedge clk);
    end
    if (!done) chk("resp_wait_expired", 0, 1);
    idle_inputs();
    chk("cmd_ready_after", 32'(bus.cmd_ready), 1);
    chk("resp_valid_after", 32'(bus.resp_valid), 0);
    chk("select_cycles", sel, esel);
    chk("backoff_cycles", boff, eboff);
    chk("bus_idle_zero", bus_bad, 0);
    chk("resp_stable", resp_bad, 0);
  endtask

  task automatic run_reset_mid();
    int guard = 0, bad = 0;
    set_plan(1'b1, 32'h0004_0010, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b1);
    bus.cmd_valid = 1; bus.cmd_rnw = 1; bus.cmd_addr = p_addr; bus.cmd_be = p_be;
    bus.cmd_wdata = '0; bus.OPB_toutSup = 1;
    @(negedge clk);
    bus.cmd_valid = 0;
    while (!bus.M_select && guard < 50) begin
      bus.OPB_MGrant = bus.M_request; guard++;
      @(negedge clk);
    end
    bus.OPB_MGrant = 0;
    chk("rst_xfer_reached", 32'(bus.M_select), 1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_select", 32'(bus.M_select), 0);
    chk("rst_mid_request", 32'(bus.M_request), 0);
    chk("rst_mid_resp_valid", 32'(bus.resp_valid), 0);
    chk("rst_mid_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rst_mid_abus", bus.M_ABus, 0);
    rst = 0;
    for (int i = 0; i < 20; i++) begin
      bus.OPB_MGrant  = 1'($urandom_range(0, 1));
      bus.OPB_xferAck = 1'($urandom_range(0, 1));
      bus.resp_ready  = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.resp_valid || !bus.cmd_ready || bus.M_request || bus.M_select) bad++;
    end
    idle_inputs();
    chk("no_resp_after_rst", bad, 0);
  endtask

  initial begin
    bus.cmd_valid = 0; bus.cmd_rnw = 0; bus.cmd_addr = '0; bus.cmd_be = '0; bus.cmd_wdata = '0;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("reset_request", 32'(bus.M_request), 0);
    chk("reset_select", 32'(bus.M_select), 0);
    chk("reset_resp_valid", 32'(bus.resp_valid), 0);
    chk("reset_resp_status", 32'(bus.resp_status), 0);
    rst = 0;
    @(negedge clk);

    // write, grant after 2 REQ cycles, ack on first XFER cycle
    set_plan(1'b0, 32'h0004_0008, 4'hF, 32'h0000_0001, 32'hA5A5_A5A5, 1'b0);
    p_gdel[0] = 2; p_kind[0] = K_ACK; p_at[0] = 1;
    run_cmd(0);
    // read, ack on 3rd XFER cycle
    set_plan(1'b1, 32'h0004_000C, 4'hF, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0);
    p_at[0] = 3;
    run_cmd(1);
    // timeout, then suppressed timeout acked after 40 cycles
    set_plan(1'b1, 32'h0004_0000, 4'h3, 32'h0, 32'h1111_2222, 1'b0);
    p_kind[0] = K_NONE;
    run_cmd(0);
    set_plan(1'b1, 32'h0004_0004, 4'hC, 32'h0, 32'h3333_4444, 1'b1);
    p_at[0] = 41;
    run_cmd(0);
    // retry on every attempt until exhausted
    set_plan(1'b0, 32'h0004_0020, 4'h1, 32'hCAFE_F00D, 32'h0, 1'b0);
    p_n = MRETRY + 1;
    for (int i = 0; i < p_n; i++) begin p_kind[i] = K_RETRY; p_at[i] = 1; p_gdel[i] = 1; end
    run_cmd(0);
    // errAck and xferAck together
    set_plan(1'b1, 32'h0004_0024, 4'hF, 32'h0, 32'h5555_AAAA, 1'b0);
    p_kind[0] = K_BOTH; p_at[0] = 2;
    run_cmd(0);
    // stalled response then an immediate back-to-back command
    set_plan(1'b1, 32'h0004_0028, 4'hF, 32'h0, 32'h0BAD_F00D, 1'b0);
    p_at[0] = 2;
    run_cmd(10);
    set_plan(1'b0, 32'h0004_002C, 4'h6, 32'h8765_4321, 32'h0, 1'b0);
    run_cmd(0);
    // reset during XFER
    run_reset_mid();

    for (int n = 0; n < 40; n++) begin
      rand_plan();
      run_cmd($urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
